hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage RV32I core (F/D/E/M/W). It generates the E-stage operand forwarding selects, load-use stalls and taken-branch flushes. It also freezes the whole pipeline while the data memory holds off an M-stage access, with a timeout. It sits beside the decode and execute stage registers and drives their stall (enable) and flush (synchronous clear) inputs. Saturating performance counters record stall and flush activity.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 30 +++
 rtl/hazard_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN,
    WAIT
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one per enabled edge and holds at all ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline: forwarding selects, load-use stalls,
// branch flushes and a memory hold-off freeze with timeout, plus stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [TO_W-1:0] ToMax = TO_W'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
  logic            lw_stall;
  logic            timeout_hit;
  logic            mem_hold;

  // Operand forwarding; the younger M-stage result wins over W.
  always_comb begin
    ForwardAE = FWD_RF;
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS1_E)) begin
      ForwardAE = FWD_MEM;
    end else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS1_E)) begin
      ForwardAE = FWD_WB;
    end

    ForwardBE = FWD_RF;
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS2_E)) begin
      ForwardBE = FWD_MEM;
    end else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS2_E)) begin
      ForwardBE = FWD_WB;
    end
  end

  assign lw_stall = ResultSrcE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

  // On the timeout cycle the access is abandoned, so the freeze lifts immediately.
  assign timeout_hit = (state_q == WAIT) && !MemReadyM && (to_q == ToMax);
  assign mem_hold    = MemReqM && !MemReadyM && !timeout_hit;

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d = WAIT;
          to_d    = TO_W'(1);
        end
      end
      WAIT: begin
        if (MemReadyM) begin
          state_d = RUN;
          to_d    = '0;
        end else if (timeout_hit) begin
          state_d = RUN;
          to_d    = '0;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        to_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // Control outputs are masked during reset so an in-progress freeze drops at once.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      if (mem_hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  assign MemErr = err_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(StallF),
    .cnt(StallCnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(FlushE),
    .cnt(FlushCnt)
  );

endmodule
